// File: rtl/pit_arb_pkg.sv
// Shared types for the PIT WISHBONE round-robin arbiter.
package pit_arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  localparam int MAX_M = 8;

  typedef logic [$clog2(MAX_M)-1:0] m_idx_t;

endpackage

// File: rtl/pit_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NUM_M.
module pit_rr_pick
  import pit_arb_pkg::*;
#(
  parameter int NUM_M = 2
) (
  input  logic [NUM_M-1:0] req,
  input  m_idx_t           ptr,
  output logic             valid,
  output m_idx_t           idx
);

  localparam int SW = $bits(m_idx_t) + 1;

  logic [NUM_M-1:0] rot;
  m_idx_t           off;
  logic [SW-1:0]    sum;

  always_comb begin
    // Rotate so the pointer's master sits at bit 0; the lowest set bit is then the winner.
    rot   = NUM_M'({req, req} >> ptr);
    valid = |req;
    off   = '0;
    for (int j = NUM_M - 1; j >= 0; j--) begin
      if (rot[j]) off = m_idx_t'(j);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= SW'(NUM_M)) sum = sum - SW'(NUM_M);
    idx = sum[$bits(m_idx_t)-1:0];
  end

endmodule

// File: rtl/pit_wb_arbiter.sv
// Round-robin arbiter sharing one PIT WISHBONE slave among NUM_M masters, one idle cycle between owners.
// Optional ack timeout enabled by defining PIT_ARB_TIMEOUT_EN.
module pit_wb_arbiter
  import pit_arb_pkg::*;
#(
  parameter int NUM_M   = 2,
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 3,
  parameter int TIMEOUT = 15
) (
  input  logic                       wb_clk,
  input  logic                       async_rst_b,
  input  logic                       wb_rst,
  input  logic [NUM_M-1:0]           m_cyc,
  input  logic [NUM_M-1:0]           m_stb,
  input  logic [NUM_M-1:0]           m_we,
  input  logic [NUM_M*A_WIDTH-1:0]   m_adr,
  input  logic [NUM_M*D_WIDTH-1:0]   m_dat_i,
  output logic [NUM_M-1:0]           m_ack,
  output logic [NUM_M-1:0]           m_err,
  output logic [D_WIDTH-1:0]         m_dat_o,
  output logic [NUM_M-1:0]           gnt,
  output logic                       s_cyc,
  output logic                       s_stb,
  output logic                       s_we,
  output logic [A_WIDTH-1:0]         s_adr,
  output logic [D_WIDTH-1:0]         s_dat_o,
  input  logic                       s_ack,
  input  logic [D_WIDTH-1:0]         s_dat_i
);

  arb_state_t       state_reg, state_next;
  logic [NUM_M-1:0] gnt_reg, gnt_next;
  m_idx_t           rr_ptr_reg, rr_ptr_next;
  m_idx_t           owner_reg, owner_next;
  m_idx_t           owner_inc;

  logic             pick_valid;
  m_idx_t           pick_idx;

  logic             active;
  logic             own_cyc, own_stb, own_we;
  logic [A_WIDTH-1:0] own_adr;
  logic [D_WIDTH-1:0] own_dat;
  logic [A_WIDTH-1:0] adr_term [NUM_M];
  logic [D_WIDTH-1:0] dat_term [NUM_M];
  logic             tmo_fire;

  pit_rr_pick #(
    .NUM_M (NUM_M)
  ) u_pick (
    .req   (m_cyc),
    .ptr   (rr_ptr_reg),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // The synchronous reset also blanks the slave side immediately, not only at the next edge.
  assign active = (state_reg == BUSY) && !wb_rst;

  assign own_cyc = |(m_cyc & gnt_reg);
  assign own_stb = |(m_stb & gnt_reg);
  assign own_we  = |(m_we  & gnt_reg);

  generate
    for (genvar gi = 0; gi < NUM_M; gi++) begin : g_mux
      assign adr_term[gi] = gnt_reg[gi] ? m_adr[gi*A_WIDTH +: A_WIDTH]   : '0;
      assign dat_term[gi] = gnt_reg[gi] ? m_dat_i[gi*D_WIDTH +: D_WIDTH] : '0;
    end
  endgenerate

  always_comb begin
    own_adr = '0;
    own_dat = '0;
    for (int i = 0; i < NUM_M; i++) begin
      own_adr = own_adr | adr_term[i];
      own_dat = own_dat | dat_term[i];
    end
  end

  assign owner_inc = (owner_reg == m_idx_t'(NUM_M - 1)) ? '0 : m_idx_t'(owner_reg + m_idx_t'(1));

`ifdef PIT_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] tmo_cnt_reg;

  // Fires on the TIMEOUT-th consecutive wait cycle, so the abort lands inside that cycle.
  assign tmo_fire = active && own_stb && !s_ack && (tmo_cnt_reg == TMO_LAST);

  always_ff @(posedge wb_clk or negedge async_rst_b) begin
    if (!async_rst_b) begin
      tmo_cnt_reg <= '0;
    end else if (wb_rst || !active || s_ack || state_next != BUSY) begin
      tmo_cnt_reg <= '0;
    end else if (own_stb) begin
      tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
    end
  end
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign tmo_fire       = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    gnt_next    = gnt_reg;
    rr_ptr_next = rr_ptr_reg;
    owner_next  = owner_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next = BUSY;
          gnt_next   = NUM_M'(1) << pick_idx;
          owner_next = pick_idx;
        end
      end
      BUSY: begin
        if (!own_cyc || tmo_fire) begin
          state_next  = IDLE;
          gnt_next    = '0;
          rr_ptr_next = owner_inc;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk or negedge async_rst_b) begin
    if (!async_rst_b) begin
      state_reg  <= IDLE;
      gnt_reg    <= '0;
      rr_ptr_reg <= '0;
      owner_reg  <= '0;
    end else if (wb_rst) begin
      state_reg  <= IDLE;
      gnt_reg    <= '0;
      rr_ptr_reg <= '0;
      owner_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      gnt_reg    <= gnt_next;
      rr_ptr_reg <= rr_ptr_next;
      owner_reg  <= owner_next;
    end
  end

  assign s_cyc   = active && own_cyc && !tmo_fire;
  assign s_stb   = active && own_stb && !tmo_fire;
  assign s_we    = active && own_we;
  assign s_adr   = active ? own_adr : '0;
  assign s_dat_o = active ? own_dat : '0;

  assign m_ack   = (active && s_ack) ? gnt_reg : '0;
  assign m_err   = tmo_fire ? gnt_reg : '0;
  assign m_dat_o = s_dat_i;
  assign gnt     = gnt_reg;

endmodule

// File: tb/tb_pit_wb_arbiter.sv
// Directed bench for pit_wb_arbiter: reset, single, contention, fairness, lock and timeout.
module tb_pit_wb_arbiter;

  localparam int NUM_M   = 2;
  localparam int D_WIDTH = 16;
  localparam int A_WIDTH = 3;
  localparam int TIMEOUT = 4;

  logic                     wb_clk = 1'b0;
  logic                     async_rst_b;
  logic                     wb_rst;
  logic [NUM_M-1:0]         m_cyc, m_stb, m_we;
  logic [NUM_M*A_WIDTH-1:0] m_adr;
  logic [NUM_M*D_WIDTH-1:0] m_dat_i;
  logic [NUM_M-1:0]         m_ack, m_err, gnt;
  logic [D_WIDTH-1:0]       m_dat_o;
  logic                     s_cyc, s_stb, s_we, s_ack;
  logic [A_WIDTH-1:0]       s_adr;
  logic [D_WIDTH-1:0]       s_dat_o, s_dat_i;

  int checks   = 0;
  int failures = 0;

  always #5 wb_clk = ~wb_clk;

  pit_wb_arbiter #(
    .NUM_M   (NUM_M),
    .D_WIDTH (D_WIDTH),
    .A_WIDTH (A_WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .wb_clk      (wb_clk),
    .async_rst_b (async_rst_b),
    .wb_rst      (wb_rst),
    .m_cyc       (m_cyc),
    .m_stb       (m_stb),
    .m_we        (m_we),
    .m_adr       (m_adr),
    .m_dat_i     (m_dat_i),
    .m_ack       (m_ack),
    .m_err       (m_err),
    .m_dat_o     (m_dat_o),
    .gnt         (gnt),
    .s_cyc       (s_cyc),
    .s_stb       (s_stb),
    .s_we        (s_we),
    .s_adr       (s_adr),
    .s_dat_o     (s_dat_o),
    .s_ack       (s_ack),
    .s_dat_i     (s_dat_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step;
    @(posedge wb_clk);
    #1;
  endtask

  initial begin
    async_rst_b = 1'b0;
    wb_rst      = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_i = '0;
    s_ack = 1'b0; s_dat_i = '0;

    // Power-on reset
    repeat (2) step;
    check_eq("rst_gnt",   32'(gnt),   32'h0);
    check_eq("rst_s_cyc", 32'(s_cyc), 32'h0);
    check_eq("rst_m_ack", 32'(m_ack), 32'h0);
    check_eq("rst_m_err", 32'(m_err), 32'h0);
    async_rst_b = 1'b1;
    step;

    // Single master 0 write
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01;
    m_adr = 6'b000_001; m_dat_i = 32'h0000_1234;
    #1;
    check_eq("single_latency_gnt", 32'(gnt),   32'h0);
    check_eq("single_latency_cyc", 32'(s_cyc), 32'h0);
    step;
    check_eq("single_gnt",     32'(gnt),     32'h1);
    check_eq("single_s_cyc",   32'(s_cyc),   32'h1);
    check_eq("single_s_stb",   32'(s_stb),   32'h1);
    check_eq("single_s_we",    32'(s_we),    32'h1);
    check_eq("single_s_adr",   32'(s_adr),   32'h1);
    check_eq("single_s_dat",   32'(s_dat_o), 32'h1234);
    check_eq("single_noack",   32'(m_ack),   32'h0);
    s_ack = 1'b1; s_dat_i = 16'hBEEF;
    #1;
    check_eq("single_m_ack",   32'(m_ack),   32'h1);
    check_eq("single_m_dat",   32'(m_dat_o), 32'hBEEF);
    step;
    s_ack = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0;
    #1;
    check_eq("single_rel_cyc", 32'(s_cyc), 32'h0);
    check_eq("single_rel_gnt", 32'(gnt),   32'h1);
    step;
    check_eq("single_idle_gnt", 32'(gnt),  32'h0);

    // Master 1 alone (pointer now 1), then synchronous reset mid-BUSY
    m_cyc = 2'b10; m_stb = 2'b10;
    m_adr = 6'b101_000; m_dat_i = 32'h5678_0000;
    step;
    check_eq("m1_gnt",   32'(gnt),   32'h2);
    check_eq("m1_s_adr", 32'(s_adr), 32'h5);
    wb_rst = 1'b1; m_cyc = '0; m_stb = '0;
    #1;
    check_eq("wbrst_s_cyc", 32'(s_cyc), 32'h0);
    step;
    wb_rst = 1'b0;
    #1;
    check_eq("wbrst_gnt", 32'(gnt), 32'h0);

    // Contention with pointer at 0, then fairness on m0 re-request
    m_cyc = 2'b11; m_stb = 2'b11;
    m_adr = 6'b101_010; m_dat_i = 32'h5678_1234;
    step;
    check_eq("cont_gnt_m0", 32'(gnt),   32'h1);
    check_eq("cont_adr_m0", 32'(s_adr), 32'h2);
    m_cyc = 2'b10; m_stb = 2'b10;
    #1;
    check_eq("cont_rel_cyc", 32'(s_cyc), 32'h0);
    step;
    m_cyc = 2'b11; m_stb = 2'b11;
    #1;
    check_eq("cont_idle_gnt", 32'(gnt),   32'h0);
    check_eq("cont_idle_cyc", 32'(s_cyc), 32'h0);
    step;
    check_eq("fair_gnt_m1", 32'(gnt),     32'h2);
    check_eq("fair_adr_m1", 32'(s_adr),   32'h5);
    check_eq("fair_dat_m1", 32'(s_dat_o), 32'h5678);

    // Locked transfer: three m1 beats while m0 keeps requesting
    s_ack = 1'b1;
    #1;
    check_eq("lock_beat1_ack", 32'(m_ack), 32'h2);
    step;
    s_ack = 1'b0; m_stb = 2'b01;
    #1;
    check_eq("lock_gap_gnt", 32'(gnt),   32'h2);
    check_eq("lock_gap_stb", 32'(s_stb), 32'h0);
    step;
    m_stb = 2'b11; s_ack = 1'b1;
    #1;
    check_eq("lock_beat2_ack", 32'(m_ack), 32'h2);
    step;
    s_ack = 1'b0; m_stb = 2'b01;
    step;
    m_stb = 2'b11; s_ack = 1'b1;
    #1;
    check_eq("lock_beat3_ack", 32'(m_ack), 32'h2);
    check_eq("lock_beat3_gnt", 32'(gnt),   32'h2);
    step;
    s_ack = 1'b0; m_cyc = 2'b01; m_stb = 2'b01;
    #1;
    check_eq("lock_rel_cyc", 32'(s_cyc), 32'h0);
    check_eq("lock_rel_gnt", 32'(gnt),   32'h2);
    step;
    check_eq("wrap_idle_gnt", 32'(gnt),  32'h0);
    step;
    check_eq("wrap_gnt_m0", 32'(gnt),    32'h1);
    check_eq("wrap_adr_m0", 32'(s_adr),  32'h2);

    // Asynchronous reset mid-BUSY
    s_ack = 1'b1; async_rst_b = 1'b0;
    #1;
    check_eq("arst_gnt",   32'(gnt),   32'h0);
    check_eq("arst_s_cyc", 32'(s_cyc), 32'h0);
    check_eq("arst_m_ack", 32'(m_ack), 32'h0);
    m_cyc = '0; m_stb = '0; s_ack = 1'b0;
    step;
    async_rst_b = 1'b1;
    step;
    step;
    check_eq("arst_hold_gnt", 32'(gnt),   32'h0);
    check_eq("arst_hold_cyc", 32'(s_cyc), 32'h0);

    // Slave never acks
    m_cyc = 2'b01; m_stb = 2'b01;
    step;
`ifdef PIT_ARB_TIMEOUT_EN
    for (int i = 1; i <= TIMEOUT - 1; i++) begin
      check_eq($sformatf("tmo_wait%0d_err", i), 32'(m_err), 32'h0);
      step;
    end
    check_eq("tmo_err",   32'(m_err), 32'h1);
    check_eq("tmo_s_stb", 32'(s_stb), 32'h0);
    check_eq("tmo_s_cyc", 32'(s_cyc), 32'h0);
    step;
    check_eq("tmo_idle_gnt", 32'(gnt),   32'h0);
    check_eq("tmo_idle_err", 32'(m_err), 32'h0);
    m_cyc = '0; m_stb = '0;
    step;
`else
    for (int i = 1; i <= 6; i++) begin
      check_eq($sformatf("notmo_wait%0d_err", i), 32'(m_err), 32'h0);
      check_eq($sformatf("notmo_wait%0d_gnt", i), 32'(gnt),   32'h1);
      step;
    end
    m_cyc = '0; m_stb = '0;
    step;
    check_eq("notmo_rel_gnt", 32'(gnt), 32'h0);
`endif
    step;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
